// File: rtl/counter_ctrl.sv
// Button/switch front end for the 3-bit up/down counter.
// Produces the counter's en step pulse and dir level.

module counter_ctrl_db #(
  parameter int unsigned CYCLES = 16,
  parameter int unsigned W      = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [W-1:0] CntMax = W'(CYCLES - 1);

  logic [1:0]   sync_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         stable_q;
  logic         stable_d;
  logic         dly_q;

  // Any agreeing cycle restarts the run of mismatches.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      dly_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      dly_q    <= stable_q;
    end
  end

  assign rise_o = stable_q & ~dly_q;

endmodule

module counter_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned DB_W            = 5,
  parameter int unsigned RUN_DIV         = 8,
  parameter int unsigned RUN_W           = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic btn_dir,
  input  logic sw_run,
  output logic en,
  output logic dir,
  output logic run_active
);

  typedef enum logic {
    MANUAL = 1'b0,
    RUN    = 1'b1
  } state_e;

  localparam logic [RUN_W-1:0] RunMax = RUN_W'(RUN_DIV - 1);

  state_e           state_q;
  logic [RUN_W-1:0] presc_q;
  logic [1:0]       run_sync_q;
  logic             en_q;
  logic             dir_q;
  logic             run_q;
  logic             step_rise;
  logic             dir_rise;

  counter_ctrl_db #(
    .CYCLES (DEBOUNCE_CYCLES),
    .W      (DB_W)
  ) u_db_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_step),
    .rise_o (step_rise)
  );

  counter_ctrl_db #(
    .CYCLES (DEBOUNCE_CYCLES),
    .W      (DB_W)
  ) u_db_dir (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw_i  (btn_dir),
    .rise_o (dir_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync_q <= '0;
    end else begin
      run_sync_q <= {run_sync_q[0], sw_run};
    end
  end

  // Step rises arriving while in RUN are simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      presc_q <= '0;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      dir_q <= dir_q ^ dir_rise;
      unique case (state_q)
        MANUAL: begin
          en_q <= step_rise;
          if (run_sync_q[1]) begin
            state_q <= RUN;
            presc_q <= '0;
            run_q   <= 1'b1;
          end else begin
            run_q   <= 1'b0;
          end
        end
        RUN: begin
          if (!run_sync_q[1]) begin
            state_q <= MANUAL;
            presc_q <= '0;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
          end else begin
            run_q <= 1'b1;
            en_q  <= (presc_q == RunMax);
            if (presc_q == RunMax) begin
              presc_q <= '0;
            end else begin
              presc_q <= presc_q + RUN_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign en         = en_q;
  assign dir        = dir_q;
  assign run_active = run_q;

endmodule
